// File: rtl/memory_responder_pkg.sv
// Shared sizing, FSM state encoding and address decode helper for the memory responder.
package memory_responder_pkg;

    localparam int unsigned MR_DEPTH_WORDS = 1024;  // 64 pages x 16 words
    localparam int unsigned MR_INDEX_W     = 10;    // log2(MR_DEPTH_WORDS)

    typedef enum logic {
        StClear = 1'b0,
        StIdle  = 1'b1
    } mr_state_e;

    // Word aligned and inside the array; anything else is an access fault.
    function automatic logic mr_addr_ok(input logic [31:0] addr, input int unsigned index_w);
        return (addr[1:0] == 2'b00) && ((addr >> (index_w + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/word_ram.sv
// Simple dual-port word storage: one synchronous write port, one synchronous read port.
// No reset on the array or the read register so it maps onto block RAM.
module word_ram #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port; the register holds its value between enabled reads.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/memory_responder.sv
// Bus-facing memory responder: sweeps the array to zero after reset or clear, then serves
// single-cycle writes and latency-1 reads, flagging bad addresses in a sticky error bit.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = MR_DEPTH_WORDS,
    parameter int unsigned INDEX_W     = MR_INDEX_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic [31:0] memory_address,
    input  logic [31:0] memory_write_data,
    output logic [31:0] memory_read_data,
    output logic        read_valid,
    output logic        busy,
    output logic        error
);

    mr_state_e          r_state;
    mr_state_e          w_state_next;
    logic [INDEX_W-1:0] r_count;
    logic [INDEX_W-1:0] w_count_next;
    logic               r_error;
    logic               w_error_next;
    logic               r_rvalid;
    logic               w_rvalid_next;
    // Forces read data to zero (after reset or a faulting read) without touching the RAM.
    logic               r_rd_zero;
    logic               w_rd_zero_next;

    logic               w_addr_ok;
    logic [INDEX_W-1:0] w_index;
    logic               w_we;
    logic [INDEX_W-1:0] w_waddr;
    logic [31:0]        w_wdata;
    logic               w_re;
    logic [31:0]        w_ram_q;

    // Next-state, sweep counter, access decode and RAM port control.
    always_comb begin
        w_addr_ok      = mr_addr_ok(memory_address, INDEX_W);
        w_index        = memory_address[INDEX_W+1:2];
        w_state_next   = r_state;
        w_count_next   = r_count;
        w_error_next   = r_error;
        w_rvalid_next  = 1'b0;
        w_rd_zero_next = r_rd_zero;
        w_we           = 1'b0;
        w_waddr        = r_count;
        w_wdata        = '0;
        w_re           = 1'b0;

        unique case (r_state)
            StClear: begin
                w_we    = 1'b1;
                w_waddr = r_count;
                if (clear) begin
                    w_count_next = '0;
                end else if (r_count == INDEX_W'(DEPTH_WORDS - 1)) begin
                    w_state_next = StIdle;
                    w_count_next = '0;
                end else begin
                    w_count_next = r_count + 1'b1;
                end
            end
            StIdle: begin
                if (clear) begin
                    w_state_next = StClear;
                    w_count_next = '0;
                end else if (memory_write) begin
                    // A simultaneous read is dropped and reported as a fault.
                    if (w_addr_ok) begin
                        w_we    = 1'b1;
                        w_waddr = w_index;
                        w_wdata = memory_write_data;
                    end
                    if (memory_read || !w_addr_ok) begin
                        w_error_next = 1'b1;
                    end
                end else if (memory_read) begin
                    w_rvalid_next = 1'b1;
                    if (w_addr_ok) begin
                        w_re           = 1'b1;
                        w_rd_zero_next = 1'b0;
                    end else begin
                        w_rd_zero_next = 1'b1;
                        w_error_next   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = StClear;
                w_count_next = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StClear;
            r_count   <= '0;
            r_error   <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rd_zero <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_error   <= w_error_next;
            r_rvalid  <= w_rvalid_next;
            r_rd_zero <= w_rd_zero_next;
        end
    end

    word_ram #(
        .DEPTH  (DEPTH_WORDS),
        .ADDR_W (INDEX_W),
        .DATA_W (32)
    ) u_word_ram (
        .clk     (clk),
        .i_we    (w_we && !reset),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_re && !reset),
        .i_raddr (w_index),
        .o_rdata (w_ram_q)
    );

    assign memory_read_data = r_rd_zero ? 32'd0 : w_ram_q;
    assign read_valid       = r_rvalid;
    assign busy             = (r_state == StClear);
    assign error            = r_error;

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: reads push expected data, the monitor pops on read_valid.
`timescale 1ns/1ps
module tb_memory_responder;

    localparam int unsigned DW   = 1024;
    localparam int          NONE = 100000;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        memory_read;
    logic        memory_write;
    logic [31:0] memory_address;
    logic [31:0] memory_write_data;
    logic [31:0] memory_read_data;
    logic        read_valid;
    logic        busy;
    logic        error;

    memory_responder dut (
        .clk               (clk),
        .reset             (reset),
        .clear             (clear),
        .memory_read       (memory_read),
        .memory_write      (memory_write),
        .memory_address    (memory_address),
        .memory_write_data (memory_write_data),
        .memory_read_data  (memory_read_data),
        .read_valid        (read_valid),
        .busy              (busy),
        .error             (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned n_total = 0;
    int unsigned n_bad = 0;
    logic [31:0] mdl [DW];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic addr_ok_m(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:12] == 20'd0);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every read_valid must match the oldest outstanding read, on its due cycle.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (read_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_rv", {31'b0, read_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rd_data", memory_read_data, e.data);
                chk("rd_lat", cyc, e.due);
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            chk("missing_rv", {31'b0, read_valid}, 32'd1);
            void'(sb.pop_front());
        end
    end

    task automatic idle_inputs();
        clear             = 1'b0;
        memory_read       = 1'b0;
        memory_write      = 1'b0;
        memory_address    = '0;
        memory_write_data = '0;
    endtask

    task automatic zero_model();
        for (int i = 0; i < int'(DW); i++) mdl[i] = '0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        memory_write      = 1'b1;
        memory_address    = a;
        memory_write_data = d;
        @(negedge clk);
        idle_inputs();
        if (addr_ok_m(a)) mdl[a[11:2]] = d;
    endtask

    task automatic do_read(input logic [31:0] a);
        logic [31:0] exp;
        exp = addr_ok_m(a) ? mdl[a[11:2]] : 32'd0;
        sb.push_back('{due: cyc + 1, data: exp});
        memory_read    = 1'b1;
        memory_address = a;
        @(negedge clk);
        idle_inputs();
    endtask

    // Counts negedge samples with busy high; optionally injects an access or a clear.
    task automatic measure_busy(input int inj_at, input int clr_at, output int n);
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            if (n == inj_at) begin
                memory_write      = 1'b1;
                memory_address    = 32'h0;
                memory_write_data = 32'hDEADBEEF;
            end
            if (n == inj_at + 1) begin
                memory_read    = 1'b1;
                memory_address = 32'h4;
            end
            if (n == clr_at) clear = 1'b1;
            n++;
            @(negedge clk);
            idle_inputs();
        end
    endtask

    task automatic do_reset(input int cycles);
        int n;
        idle_inputs();
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_rv", {31'b0, read_valid}, 32'd0);
        chk("rst_err", {31'b0, error}, 32'd0);
        chk("rst_data", memory_read_data, 32'd0);
        reset = 1'b0;
        measure_busy(NONE, NONE, n);
        chk("busy_len", 32'(n), 32'd1024);
        chk("post_rst_err", {31'b0, error}, 32'd0);
        zero_model();
    endtask

    initial begin
        int n;
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        do_reset(3);

        // Basic reads and writes, including read of the word written the cycle before.
        do_read(32'h0000_0FFC);
        do_write(32'h0000_0040, 32'hCAFEBABE);
        do_read(32'h0000_0040);
        do_write(32'h0000_001C, 32'h0123_4567);
        do_write(32'h0000_0FFC, 32'h8000_0001);
        do_read(32'h0000_001C);
        do_read(32'h0000_0FFC);
        do_read(32'h0000_0040);
        repeat (3) @(negedge clk);
        chk("hold_data", memory_read_data, 32'hCAFEBABE);
        chk("hold_rv", {31'b0, read_valid}, 32'd0);
        chk("err_clean", {31'b0, error}, 32'd0);

        // Read and write together: write only, fault, no read_valid.
        memory_read       = 1'b1;
        memory_write      = 1'b1;
        memory_address    = 32'h0000_0010;
        memory_write_data = 32'h1234_5678;
        @(negedge clk);
        idle_inputs();
        mdl[4] = 32'h1234_5678;
        chk("err_both", {31'b0, error}, 32'd1);
        do_read(32'h0000_0010);

        // Faulting addresses must not touch the array and read back zero.
        do_reset(2);
        do_write(32'h0000_0040, 32'hA5A5_5A5A);
        chk("err_valid_wr", {31'b0, error}, 32'd0);
        do_read(32'h0000_0042);
        chk("err_misalign", {31'b0, error}, 32'd1);
        do_write(32'h0000_0043, 32'hFFFF_FFFF);
        do_write(32'h0000_1000, 32'h0000_0BAD);
        do_read(32'h0000_1000);
        do_read(32'h0000_0040);
        do_read(32'h0000_0000);
        @(negedge clk);
        chk("err_sticky", {31'b0, error}, 32'd1);

        // Clear with a same-cycle read, accesses during busy, and a restart mid-sweep.
        do_reset(2);
        for (int i = 0; i < 16; i++) do_write(32'(i * 68), 32'hF00D_0000 + 32'(i));
        do_write(32'h0000_0004, 32'h1111_1111);
        clear          = 1'b1;
        memory_read    = 1'b1;
        memory_address = 32'h0000_0004;
        @(negedge clk);
        idle_inputs();
        measure_busy(20, 30, n);
        chk("clr_busy_len", 32'(n), 32'd1055);
        chk("clr_err", {31'b0, error}, 32'd0);
        zero_model();
        for (int i = 0; i < int'(DW); i++) do_read(32'(i * 4));

        // Reset at sweep counter 500 clears error and restarts a full sweep.
        do_read(32'h0000_0002);
        @(negedge clk);
        chk("err_pre_rst", {31'b0, error}, 32'd1);
        clear = 1'b1;
        @(negedge clk);
        idle_inputs();
        repeat (500) @(negedge clk);
        chk("mid_sweep_busy", {31'b0, busy}, 32'd1);
        do_reset(2);
        do_read(32'h0000_0000);

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
